// File: rtl/axi_log_capture.sv
// axi_log_capture: snoops AXI AR/AW handshakes into per-channel FIFOs and drains
// them round-robin into a one-entry-per-cycle log stream. Optional: AXI_LOG_CAPTURE_FILTER_EN.
module axi_log_capture #(
  parameter int unsigned AXI_ADDR_BITW = 32,
  parameter int unsigned AXI_ID_BITW   = 8,
  parameter int unsigned AXI_LEN_BITW  = 8,
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned DROP_CNT_BITW = 16
) (
  input  logic                     Clk_CI,
  input  logic                     Rst_RI,
  input  logic                     ArValid_SI,
  input  logic                     ArReady_SI,
  input  logic [AXI_ID_BITW-1:0]   ArId_DI,
  input  logic [AXI_ADDR_BITW-1:0] ArAddr_DI,
  input  logic [AXI_LEN_BITW-1:0]  ArLen_DI,
  input  logic                     AwValid_SI,
  input  logic                     AwReady_SI,
  input  logic [AXI_ID_BITW-1:0]   AwId_DI,
  input  logic [AXI_ADDR_BITW-1:0] AwAddr_DI,
  input  logic [AXI_LEN_BITW-1:0]  AwLen_DI,
  input  logic                     LogFull_SI,
  input  logic                     Clear_SI,
  input  logic [AXI_ADDR_BITW-1:0] FiltBase_DI,
  input  logic [AXI_ADDR_BITW-1:0] FiltMask_DI,
  output logic                     LogValid_SO,
  output logic                     LogWrite_SO,
  output logic [AXI_ID_BITW-1:0]   LogId_DO,
  output logic [AXI_ADDR_BITW-1:0] LogAddr_DO,
  output logic [AXI_LEN_BITW-1:0]  LogLen_DO,
  output logic [DROP_CNT_BITW-1:0] DropCnt_DO
);

  localparam int unsigned ENTRY_BITW = AXI_ID_BITW + AXI_ADDR_BITW + AXI_LEN_BITW;
  localparam int unsigned PTR_BITW   = $clog2(FIFO_DEPTH);
  localparam int unsigned PCNT_BITW  = PTR_BITW + 1;
  localparam int unsigned SUM_BITW   = DROP_CNT_BITW + 2;
  localparam logic [DROP_CNT_BITW-1:0] DROP_MAX = '1;

  logic [ENTRY_BITW-1:0]    r_ar_mem [FIFO_DEPTH];
  logic [ENTRY_BITW-1:0]    r_aw_mem [FIFO_DEPTH];
  logic [PCNT_BITW-1:0]     r_ar_wptr, r_ar_rptr, r_aw_wptr, r_aw_rptr;
  logic                     r_prio_aw;
  logic                     r_log_valid, r_log_write;
  logic [AXI_ID_BITW-1:0]   r_log_id;
  logic [AXI_ADDR_BITW-1:0] r_log_addr;
  logic [AXI_LEN_BITW-1:0]  r_log_len;
  logic [DROP_CNT_BITW-1:0] r_drop_cnt;

  logic                     w_ar_match, w_aw_match, w_ar_hs, w_aw_hs;
  logic                     w_ar_empty, w_aw_empty, w_ar_full, w_aw_full;
  logic                     w_ar_pop, w_aw_pop, w_pop;
  logic                     w_ar_push, w_aw_push, w_ar_drop, w_aw_drop, w_log_drop;
  logic                     w_ar_wr, w_aw_wr;
  logic [1:0]               w_drop_inc;
  logic [SUM_BITW-1:0]      w_drop_sum;
  logic [DROP_CNT_BITW-1:0] w_drop_next;
  logic [ENTRY_BITW-1:0]    w_ar_entry, w_aw_entry, w_pop_entry;

`ifdef AXI_LOG_CAPTURE_FILTER_EN
  assign w_ar_match = (ArAddr_DI & FiltMask_DI) == (FiltBase_DI & FiltMask_DI);
  assign w_aw_match = (AwAddr_DI & FiltMask_DI) == (FiltBase_DI & FiltMask_DI);
`else
  logic w_unused_filt;
  assign w_unused_filt = ^{FiltBase_DI, FiltMask_DI};
  assign w_ar_match    = 1'b1;
  assign w_aw_match    = 1'b1;
`endif

  assign w_ar_hs    = ArValid_SI & ArReady_SI & w_ar_match;
  assign w_aw_hs    = AwValid_SI & AwReady_SI & w_aw_match;
  assign w_ar_entry = {ArId_DI, ArAddr_DI, ArLen_DI};
  assign w_aw_entry = {AwId_DI, AwAddr_DI, AwLen_DI};

  assign w_ar_empty = (r_ar_wptr == r_ar_rptr);
  assign w_aw_empty = (r_aw_wptr == r_aw_rptr);
  assign w_ar_full  = ((r_ar_wptr - r_ar_rptr) == PCNT_BITW'(FIFO_DEPTH));
  assign w_aw_full  = ((r_aw_wptr - r_aw_rptr) == PCNT_BITW'(FIFO_DEPTH));

  // Round-robin only matters under contention; a lone non-empty FIFO always wins.
  assign w_ar_pop = ~w_ar_empty & (w_aw_empty | ~r_prio_aw);
  assign w_aw_pop = ~w_aw_empty & (w_ar_empty | r_prio_aw);
  assign w_pop    = w_ar_pop | w_aw_pop;

  assign w_pop_entry = w_ar_pop ? r_ar_mem[r_ar_rptr[PTR_BITW-1:0]]
                                : r_aw_mem[r_aw_rptr[PTR_BITW-1:0]];

  // A full FIFO still accepts a push when it is popped in the same cycle.
  assign w_ar_push  = w_ar_hs & (~w_ar_full | w_ar_pop);
  assign w_aw_push  = w_aw_hs & (~w_aw_full | w_aw_pop);
  assign w_ar_drop  = w_ar_hs & w_ar_full & ~w_ar_pop;
  assign w_aw_drop  = w_aw_hs & w_aw_full & ~w_aw_pop;
  assign w_log_drop = w_pop & LogFull_SI;

  assign w_drop_inc  = 2'(w_ar_drop) + 2'(w_aw_drop) + 2'(w_log_drop);
  assign w_drop_sum  = SUM_BITW'(r_drop_cnt) + SUM_BITW'(w_drop_inc);
  assign w_drop_next = (w_drop_sum > SUM_BITW'(DROP_MAX)) ? DROP_MAX
                                                          : w_drop_sum[DROP_CNT_BITW-1:0];

  assign w_ar_wr = w_ar_push & ~Rst_RI & ~Clear_SI;
  assign w_aw_wr = w_aw_push & ~Rst_RI & ~Clear_SI;

  // FIFO storage needs no reset; the pointers define validity.
  always_ff @(posedge Clk_CI) begin
    if (w_ar_wr) r_ar_mem[r_ar_wptr[PTR_BITW-1:0]] <= w_ar_entry;
    if (w_aw_wr) r_aw_mem[r_aw_wptr[PTR_BITW-1:0]] <= w_aw_entry;
  end

  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) begin
      r_ar_wptr   <= '0;
      r_ar_rptr   <= '0;
      r_aw_wptr   <= '0;
      r_aw_rptr   <= '0;
      r_prio_aw   <= 1'b0;
      r_log_valid <= 1'b0;
      r_log_write <= 1'b0;
      r_log_id    <= '0;
      r_log_addr  <= '0;
      r_log_len   <= '0;
      r_drop_cnt  <= '0;
    end else if (Clear_SI) begin
      r_ar_wptr   <= '0;
      r_ar_rptr   <= '0;
      r_aw_wptr   <= '0;
      r_aw_rptr   <= '0;
      r_prio_aw   <= 1'b0;
      r_log_valid <= 1'b0;
      r_drop_cnt  <= '0;
    end else begin
      if (w_ar_push) r_ar_wptr <= r_ar_wptr + PCNT_BITW'(1);
      if (w_aw_push) r_aw_wptr <= r_aw_wptr + PCNT_BITW'(1);
      if (w_ar_pop)  r_ar_rptr <= r_ar_rptr + PCNT_BITW'(1);
      if (w_aw_pop)  r_aw_rptr <= r_aw_rptr + PCNT_BITW'(1);
      if (~w_ar_empty & ~w_aw_empty) r_prio_aw <= ~r_prio_aw;
      r_log_valid <= w_pop & ~LogFull_SI;
      if (w_pop & ~LogFull_SI) begin
        r_log_write                       <= w_aw_pop;
        {r_log_id, r_log_addr, r_log_len} <= w_pop_entry;
      end
      r_drop_cnt <= w_drop_next;
    end
  end

  assign LogValid_SO = r_log_valid;
  assign LogWrite_SO = r_log_write;
  assign LogId_DO    = r_log_id;
  assign LogAddr_DO  = r_log_addr;
  assign LogLen_DO   = r_log_len;
  assign DropCnt_DO  = r_drop_cnt;

endmodule

// File: tb/tb_axi_log_capture.sv
// tb_axi_log_capture: directed + randomized bench for axi_log_capture against a
// queue-based reference model. Honours AXI_LOG_CAPTURE_FILTER_EN when defined.
module tb_axi_log_capture;

  localparam int unsigned AW = 32, IW = 8, LW = 8, DEPTH = 4, DW = 4;
  localparam int DROP_MAX = (1 << DW) - 1;
`ifdef AXI_LOG_CAPTURE_FILTER_EN
  localparam bit FILT_EN = 1'b1;
`else
  localparam bit FILT_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, ar_valid, ar_ready, aw_valid, aw_ready, log_full, clr;
  logic [IW-1:0] ar_id, aw_id;
  logic [AW-1:0] ar_addr, aw_addr, filt_base, filt_mask;
  logic [LW-1:0] ar_len, aw_len;
  logic          o_valid, o_write;
  logic [IW-1:0] o_id;
  logic [AW-1:0] o_addr;
  logic [LW-1:0] o_len;
  logic [DW-1:0] o_drop;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic          write;
    logic [IW-1:0] id;
    logic [AW-1:0] addr;
    logic [LW-1:0] len;
  } ent_t;

  ent_t q_ar[$];
  ent_t q_aw[$];
  bit   prio_aw;
  bit   exp_valid;
  ent_t exp_e;
  int   exp_drop;

  axi_log_capture #(
    .AXI_ADDR_BITW(AW), .AXI_ID_BITW(IW), .AXI_LEN_BITW(LW),
    .FIFO_DEPTH(DEPTH), .DROP_CNT_BITW(DW)
  ) dut (
    .Clk_CI(clk), .Rst_RI(rst),
    .ArValid_SI(ar_valid), .ArReady_SI(ar_ready), .ArId_DI(ar_id), .ArAddr_DI(ar_addr), .ArLen_DI(ar_len),
    .AwValid_SI(aw_valid), .AwReady_SI(aw_ready), .AwId_DI(aw_id), .AwAddr_DI(aw_addr), .AwLen_DI(aw_len),
    .LogFull_SI(log_full), .Clear_SI(clr), .FiltBase_DI(filt_base), .FiltMask_DI(filt_mask),
    .LogValid_SO(o_valid), .LogWrite_SO(o_write), .LogId_DO(o_id), .LogAddr_DO(o_addr),
    .LogLen_DO(o_len), .DropCnt_DO(o_drop)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit addr_match(input logic [AW-1:0] a);
    return !FILT_EN || ((a & filt_mask) == (filt_base & filt_mask));
  endfunction

  // Reference: two bounded queues, one log slot per cycle, saturating loss counter.
  task automatic model_step();
    int   drops;
    bit   have;
    ent_t e;
    drops = 0;
    have  = 1'b0;
    e     = '0;
    if (rst || clr) begin
      q_ar.delete();
      q_aw.delete();
      prio_aw   = 1'b0;
      exp_valid = 1'b0;
      exp_drop  = 0;
      if (rst) exp_e = '0;
    end else begin
      if (q_ar.size() > 0 && (q_aw.size() == 0 || !prio_aw)) begin
        e = q_ar.pop_front();
        have = 1'b1;
        if (q_aw.size() > 0) prio_aw = 1'b1;
      end else if (q_aw.size() > 0) begin
        e = q_aw.pop_front();
        have = 1'b1;
        if (q_ar.size() > 0) prio_aw = 1'b0;
      end
      exp_valid = 1'b0;
      if (have) begin
        if (log_full) drops++;
        else begin
          exp_valid = 1'b1;
          exp_e     = e;
        end
      end
      if (ar_valid && ar_ready && addr_match(ar_addr)) begin
        if (q_ar.size() < DEPTH) begin
          e = '{write: 1'b0, id: ar_id, addr: ar_addr, len: ar_len};
          q_ar.push_back(e);
        end else drops++;
      end
      if (aw_valid && aw_ready && addr_match(aw_addr)) begin
        if (q_aw.size() < DEPTH) begin
          e = '{write: 1'b1, id: aw_id, addr: aw_addr, len: aw_len};
          q_aw.push_back(e);
        end else drops++;
      end
      exp_drop = (exp_drop + drops > DROP_MAX) ? DROP_MAX : exp_drop + drops;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    chk("log_valid", 64'(o_valid), 64'(exp_valid));
    chk("drop_cnt", 64'(o_drop), 64'(exp_drop));
    if (exp_valid) begin
      chk("log_write", 64'(o_write), 64'(exp_e.write));
      chk("log_id", 64'(o_id), 64'(exp_e.id));
      chk("log_addr", 64'(o_addr), 64'(exp_e.addr));
      chk("log_len", 64'(o_len), 64'(exp_e.len));
    end
  endtask

  task automatic idle();
    ar_valid = 1'b0; ar_ready = 1'b0; aw_valid = 1'b0; aw_ready = 1'b0;
  endtask

  task automatic set_ar(input logic [IW-1:0] id, input logic [AW-1:0] addr, input logic [LW-1:0] len);
    ar_valid = 1'b1; ar_ready = 1'b1; ar_id = id; ar_addr = addr; ar_len = len;
  endtask

  task automatic set_aw(input logic [IW-1:0] id, input logic [AW-1:0] addr, input logic [LW-1:0] len);
    aw_valid = 1'b1; aw_ready = 1'b1; aw_id = id; aw_addr = addr; aw_len = len;
  endtask

  task automatic do_reset();
    rst = 1'b1; clr = 1'b0; log_full = 1'b0;
    idle();
    cycle();
    rst = 1'b0;
    chk("rst_write", 64'(o_write), 64'd0);
    chk("rst_id", 64'(o_id), 64'd0);
    chk("rst_addr", 64'(o_addr), 64'd0);
    chk("rst_len", 64'(o_len), 64'd0);
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; log_full = 1'b0;
    ar_id = '0; ar_addr = '0; ar_len = '0; aw_id = '0; aw_addr = '0; aw_len = '0;
    filt_base = '0; filt_mask = '0;
    idle();
    prio_aw = 1'b0; exp_valid = 1'b0; exp_e = '0; exp_drop = 0;
    do_reset();
    do_reset();

    // T1: single AR, visible exactly two cycles after the handshake
    set_ar(8'd3, 32'h1000, 8'd7);
    cycle();
    idle();
    chk("t1_valid_c1", 64'(o_valid), 64'd0);
    cycle();
    chk("t1_valid_c2", 64'(o_valid), 64'd1);
    chk("t1_write", 64'(o_write), 64'd0);
    chk("t1_id", 64'(o_id), 64'd3);
    chk("t1_addr", 64'(o_addr), 64'h1000);
    chk("t1_len", 64'(o_len), 64'd7);
    cycle();
    chk("t1_valid_c3", 64'(o_valid), 64'd0);

    // T2: simultaneous AR/AW, then again with priority on AW
    do_reset();
    for (int r = 0; r < 2; r++) begin
      set_ar(8'h10, 32'hA000, 8'd1);
      set_aw(8'h20, 32'hB000, 8'd2);
      cycle();
      idle();
      cycle();
      chk("t2_first_valid", 64'(o_valid), 64'd1);
      chk("t2_first_write", 64'(o_write), (r == 0) ? 64'd0 : 64'd1);
      cycle();
      chk("t2_second_valid", 64'(o_valid), 64'd1);
      chk("t2_second_write", 64'(o_write), (r == 0) ? 64'd1 : 64'd0);
      cycle();
    end

    // T3: AW stream alone keeps up; AR+AW together overflow
    do_reset();
    for (int i = 0; i < 10; i++) begin
      set_aw(8'(i), 32'h2000 + 32'(i * 4), 8'(i));
      cycle();
    end
    chk("t3_no_drop", 64'(o_drop), 64'd0);
    for (int i = 0; i < 20; i++) begin
      set_ar(8'(i + 64), 32'h3000 + 32'(i), 8'(i));
      set_aw(8'(i + 128), 32'h4000 + 32'(i), 8'(i));
      cycle();
    end
    chk("t3_drops_seen", 64'(o_drop != '0), 64'd1);
    log_full = 1'b1;
    for (int i = 0; i < 8; i++) cycle();
    chk("t3_saturated", 64'(o_drop), 64'(DROP_MAX));
    log_full = 1'b0;
    idle();
    for (int i = 0; i < 10; i++) cycle();

    // T4: logger full, five AR handshakes all counted as lost
    do_reset();
    log_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      set_ar(8'(i), 32'h5000 + 32'(i), 8'd0);
      cycle();
    end
    idle();
    for (int i = 0; i < 3; i++) cycle();
    chk("t4_drop5", 64'(o_drop), 64'd5);
    log_full = 1'b0;
    cycle();
    chk("t4_drained", 64'(o_valid), 64'd0);

    // T5: clear with backlog and a concurrent AW handshake
    do_reset();
    for (int i = 0; i < 3; i++) begin
      set_ar(8'(i), 32'h6000 + 32'(i), 8'd1);
      set_aw(8'(i), 32'h7000 + 32'(i), 8'd1);
      cycle();
    end
    idle();
    set_aw(8'hEE, 32'h7777, 8'd3);
    clr = 1'b1;
    cycle();
    clr = 1'b0;
    idle();
    for (int i = 0; i < 4; i++) begin
      chk("t5_no_valid", 64'(o_valid), 64'd0);
      chk("t5_drop0", 64'(o_drop), 64'd0);
      cycle();
    end

`ifdef AXI_LOG_CAPTURE_FILTER_EN
    // T6: address filter
    do_reset();
    filt_base = 32'h4000_0000;
    filt_mask = 32'hF000_0000;
    set_ar(8'h01, 32'h4000_0010, 8'd2);
    cycle();
    idle();
    cycle();
    chk("t6_match_valid", 64'(o_valid), 64'd1);
    chk("t6_match_addr", 64'(o_addr), 64'h4000_0010);
    set_aw(8'h02, 32'h8000_0000, 8'd2);
    cycle();
    idle();
    cycle();
    chk("t6_nomatch_valid", 64'(o_valid), 64'd0);
    chk("t6_drop0", 64'(o_drop), 64'd0);
    filt_mask = '0;
`endif

    // Randomized traffic with occasional full, clear and reset
    do_reset();
    if (FILT_EN) begin
      filt_base = {4'($urandom_range(0, 3)), 28'h0};
      filt_mask = 32'hF000_0000;
    end
    for (int i = 0; i < 400; i++) begin
      ar_valid = 1'($urandom_range(0, 1));
      ar_ready = ($urandom_range(0, 3) != 0);
      aw_valid = 1'($urandom_range(0, 1));
      aw_ready = ($urandom_range(0, 3) != 0);
      ar_id    = 8'($urandom);
      aw_id    = 8'($urandom);
      ar_addr  = {4'($urandom_range(0, 3)), 28'($urandom)};
      aw_addr  = {4'($urandom_range(0, 3)), 28'($urandom)};
      ar_len   = 8'($urandom);
      aw_len   = 8'($urandom);
      log_full = ($urandom_range(0, 7) == 0);
      clr      = ($urandom_range(0, 63) == 0);
      rst      = ($urandom_range(0, 127) == 0);
      if (FILT_EN && $urandom_range(0, 31) == 0) filt_mask = '0;
      cycle();
    end
    rst = 1'b0; clr = 1'b0; log_full = 1'b0;
    idle();
    for (int i = 0; i < 12; i++) cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
